// File: rtl/seq_signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding,
// counter sizing and the conditional two's-complement negate used for sign fix-up.
package seq_signed_divider_pkg;

  // Widest operand the negate helper handles (2*width for width up to 128).
  localparam int MAX_W = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  function automatic int cnt_width(input int w);
    return $clog2(2 * w + 1);
  endfunction

  // Callers zero/sign-extend into MAX_W and truncate the result; the low bits
  // of a MAX_W negation equal the negation modulo any narrower power of two.
  function automatic logic [MAX_W-1:0] cond_negate(input logic neg,
                                                   input logic [MAX_W-1:0] v);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/seq_signed_divider_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial-subtract
// the divisor magnitude, keep or restore.
module div_restoring_step #(
  parameter int width = 128
) (
  input  logic [width:0] rem_i,
  input  logic           bit_i,
  input  logic [width:0] dvs_i,
  output logic [width:0] rem_o,
  output logic           qbit_o
);

  logic [width:0]   shifted;
  logic [width+1:0] diff;

  // The partial remainder stays below |d| <= 2^(width-1), so the shifted value
  // always fits in width+1 bits and the top rem_i bit is known zero.
  assign shifted = (width+1)'({rem_i, bit_i});
  assign diff    = {1'b0, shifted} - {1'b0, dvs_i};
  assign qbit_o  = ~diff[width+1];
  assign rem_o   = qbit_o ? (width+1)'(diff) : shifted;

endmodule

// File: rtl/seq_signed_divider.sv
// Iterative signed divider: 2*width-bit dividend by width-bit divisor, restoring
// division on magnitudes over 2*width cycles followed by a sign fix-up.
module seq_signed_divider
  import seq_signed_divider_pkg::*;
#(
  parameter int width = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2*width-1:0]   n,
  input  logic [width-1:0]     d,
  input  logic                 enable,
  output logic [2*width-1:0]   q,
  output logic [width-1:0]     r,
  output logic                 done,
  output logic                 busy,
  output logic                 div_by_zero,
  output logic                 overflow
);

  localparam int DW = 2 * width;
  localparam int CW = cnt_width(width);
  localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);
  localparam logic [DW-1:0] N_MIN     = {1'b1, {(DW-1){1'b0}}};

  state_e           state_q, state_d;
  logic [DW-1:0]    n_q, n_d;
  logic [width-1:0] d_q, d_d;
  logic [DW-1:0]    dvd_q, dvd_d;
  logic [width:0]   dvs_q, dvs_d;
  logic [width:0]   rem_q, rem_d;
  logic [DW-1:0]    quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [DW-1:0]    q_q, q_d;
  logic [width-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [width:0]   step_rem;
  logic             step_qbit;
  logic             is_dbz, is_ovf;

  div_restoring_step #(.width(width)) u_step (
    .rem_i  (rem_q),
    .bit_i  (dvd_q[DW-1]),
    .dvs_i  (dvs_q),
    .rem_o  (step_rem),
    .qbit_o (step_qbit)
  );

  assign is_dbz = (d_q == '0);
  assign is_ovf = (n_q == N_MIN) && (d_q == '1);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    d_d     = d_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (enable) begin
          n_d     = n;
          d_d     = d;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        dvd_d   = DW'(cond_negate(n_q[DW-1], MAX_W'(n_q)));
        dvs_d   = (width+1)'(cond_negate(d_q[width-1], MAX_W'({d_q[width-1], d_q})));
        qneg_d  = n_q[DW-1] ^ d_q[width-1];
        rneg_d  = n_q[DW-1];
        rem_d   = '0;
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        rem_d = step_rem;
        quo_d = {quo_q[DW-2:0], step_qbit};
        dvd_d = dvd_q << 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = S_FIX;
      end
      S_FIX: begin
        dbz_d = is_dbz;
        ovf_d = is_ovf;
        if (is_dbz) begin
          q_d = '1;
          r_d = n_q[width-1:0];
        end else begin
          // Overflow needs no special case: the magnitude 2^(DW-1) wraps by itself.
          q_d = DW'(cond_negate(qneg_q, MAX_W'(quo_q)));
          r_d = width'(cond_negate(rneg_q, MAX_W'(width'(rem_q))));
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  // NOTE: working datapath registers carry no reset; each is loaded in IDLE or PREP before use.
  always_ff @(posedge clk) begin
    n_q    <= n_d;
    d_q    <= d_d;
    dvd_q  <= dvd_d;
    dvs_q  <= dvs_d;
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    cnt_q  <= cnt_d;
    qneg_q <= qneg_d;
    rneg_q <= rneg_d;
  end

  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_seq_signed_divider.sv
// Self-checking bench for seq_signed_divider: directed vectors at width 8,
// handshake scenarios, and a small model-checked sweep at widths 8 and 128.
module tb_seq_signed_divider;

  logic clk = 1'b0;
  logic reset;

  logic [15:0]  n8;
  logic [7:0]   d8;
  logic         en8;
  logic [15:0]  q8;
  logic [7:0]   r8;
  logic         done8, busy8, dbz8, ovf8;

  logic [255:0] n128;
  logic [127:0] d128;
  logic         en128;
  logic [255:0] q128;
  logic [127:0] r128;
  logic         done128, busy128, dbz128, ovf128;

  int n_vec = 0;
  int n_miscompare = 0;

  always #5 clk = ~clk;

  seq_signed_divider #(.width(8)) u_dut8 (
    .clk(clk), .reset(reset), .n(n8), .d(d8), .enable(en8),
    .q(q8), .r(r8), .done(done8), .busy(busy8),
    .div_by_zero(dbz8), .overflow(ovf8)
  );

  seq_signed_divider #(.width(128)) u_dut128 (
    .clk(clk), .reset(reset), .n(n128), .d(d128), .enable(en128),
    .q(q128), .r(r128), .done(done128), .busy(busy128),
    .div_by_zero(dbz128), .overflow(ovf128)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One width-8 operation: inputs scrambled after the accept edge to prove latching.
  task automatic run8(input string tag, input logic [15:0] nn, input logic [7:0] dd,
                      input logic [15:0] eq, input logic [7:0] er,
                      input logic edbz, input logic eovf);
    int lat;
    @(negedge clk);
    n8 = nn; d8 = dd; en8 = 1'b1;
    @(posedge clk);
    #1;
    en8 = 1'b0; n8 = ~nn; d8 = ~dd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) check({tag, " busy"}, 256'(busy8), 256'(1));
    end while (!done8 && lat < 100);
    check({tag, " latency"}, 256'(lat), 256'(19));
    check({tag, " q"}, 256'(q8), 256'(eq));
    check({tag, " r"}, 256'(r8), 256'(er));
    check({tag, " flags"}, 256'({dbz8, ovf8}), 256'({edbz, eovf}));
  endtask

  task automatic run128(input string tag, input logic [255:0] nn, input logic [127:0] dd,
                        input logic [255:0] eq, input logic [127:0] er);
    int lat;
    @(negedge clk);
    n128 = nn; d128 = dd; en128 = 1'b1;
    @(posedge clk);
    #1;
    en128 = 1'b0; n128 = ~nn; d128 = ~dd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done128 && lat < 400);
    check({tag, " latency"}, 256'(lat), 256'(259));
    check({tag, " q"}, q128, eq);
    check({tag, " r"}, 256'(r128), 256'(er));
    check({tag, " flags"}, 256'({dbz128, ovf128}), 256'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_at[4];
    int n_done;
    int waited;
    logic [15:0] rn8;
    logic [7:0]  rd8;
    logic signed [15:0] sn8, eq8, er8;
    logic signed [7:0]  sd8;
    logic [255:0] rn128;
    logic [127:0] rd128;
    logic signed [255:0] sn128, eq128, er128;
    logic signed [127:0] sd128;

    reset = 1'b1;
    en8 = 1'b0; n8 = '0; d8 = '0;
    en128 = 1'b0; n128 = '0; d128 = '0;
    repeat (3) @(negedge clk);
    check("reset q8", 256'(q8), 256'(0));
    check("reset r8", 256'(r8), 256'(0));
    check("reset ctl8", 256'({done8, busy8, dbz8, ovf8}), 256'(0));
    check("reset ctl128", 256'({q128 != '0, r128 != '0, done128, busy128, dbz128, ovf128}), 256'(0));
    reset = 1'b0;

    // Directed width-8 vectors: name, n, d, q, r, div_by_zero, overflow.
    run8("pp",      16'd100,   8'd7,    16'd14,    8'd2,    1'b0, 1'b0);
    run8("np",      16'hFF9C,  8'd7,    16'hFFF2,  8'hFE,   1'b0, 1'b0);
    run8("pn",      16'd100,   8'hF9,   16'hFFF2,  8'd2,    1'b0, 1'b0);
    run8("nn",      16'hFF9C,  8'hF9,   16'd14,    8'hFE,   1'b0, 1'b0);
    run8("ovf",     16'h8000,  8'hFF,   16'h8000,  8'h00,   1'b0, 1'b1);
    run8("min_d1",  16'h8000,  8'h01,   16'h8000,  8'h00,   1'b0, 1'b0);
    run8("dbz",     16'd1234,  8'h00,   16'hFFFF,  8'hD2,   1'b1, 1'b0);
    run8("max_dmin",16'h7FFF,  8'h80,   16'hFF01,  8'h7F,   1'b0, 1'b0);
    run8("min_dmin",16'h8000,  8'h80,   16'h0100,  8'h00,   1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check("hold q", 256'(q8), 256'(16'h0100));
    check("hold done", 256'({done8, busy8}), 256'(0));

    // Enable pulsed mid-iteration must be ignored.
    @(negedge clk);
    n8 = 16'd100; d8 = 8'd7; en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    repeat (5) @(negedge clk);
    n8 = 16'd50; d8 = 8'd5; en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    n_done = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    check("ignored enable dones", 256'(n_done), 256'(1));
    check("ignored enable q", 256'(q8), 256'(14));

    // Enable held high: back-to-back operations every 2*width+4 cycles.
    n8 = 16'd100; d8 = 8'd7; en8 = 1'b1;
    n_done = 0;
    for (int c = 1; c <= 70; c++) begin
      @(negedge clk);
      if (done8) begin
        if (n_done < 4) done_at[n_done] = c;
        n_done++;
      end
    end
    en8 = 1'b0;
    check("held dones", 256'(n_done), 256'(3));
    check("held first", 256'(done_at[0]), 256'(19));
    check("held gap1", 256'(done_at[1] - done_at[0]), 256'(20));
    check("held gap2", 256'(done_at[2] - done_at[1]), 256'(20));
    check("held q", 256'(q8), 256'(14));
    waited = 0;
    while (busy8 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check("held drain", 256'(busy8), 256'(0));

    // Reset mid-iteration aborts with outputs cleared and no done.
    @(negedge clk);
    n8 = 16'hFF9C; d8 = 8'd7; en8 = 1'b1;
    @(negedge clk);
    en8 = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort q", 256'(q8), 256'(0));
    check("abort ctl", 256'({r8, done8, busy8, dbz8, ovf8}), 256'(0));
    reset = 1'b0;
    n_done = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    check("abort dones", 256'(n_done), 256'(0));

    // Model-checked sweep at width 8 (truncating division, remainder follows n).
    for (int i = 0; i < 6; i++) begin
      rn8 = 16'($urandom);
      rd8 = 8'($urandom);
      if (rd8 == 8'h00) rd8 = 8'h03;
      if (rn8 == 16'h8000 && rd8 == 8'hFF) rd8 = 8'h7F;
      sn8 = rn8;
      sd8 = rd8;
      eq8 = sn8 / sd8;
      er8 = sn8 % sd8;
      run8($sformatf("rand8_%0d", i), rn8, rd8, $unsigned(eq8), er8[7:0], 1'b0, 1'b0);
    end

    // Width 128: one directed vector, then a short model-checked sweep.
    run128("w128_np", -256'sd100, 128'd7, -256'sd14, -128'sd2);
    for (int i = 0; i < 3; i++) begin
      for (int w = 0; w < 8; w++) rn128[w*32 +: 32] = $urandom;
      for (int w = 0; w < 4; w++) rd128[w*32 +: 32] = $urandom;
      if (i == 1) rd128 = 128'(rd128[40:0]) | 128'd1;
      if (i == 2) rd128 = -rd128;
      if (rd128 == '0) rd128 = 128'd5;
      sn128 = rn128;
      sd128 = rd128;
      eq128 = sn128 / sd128;
      er128 = sn128 % sd128;
      run128($sformatf("rand128_%0d", i), rn128, rd128, $unsigned(eq128), er128[127:0]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
